// File: rtl/fb_arbiter.sv
// Shares one single-port pixel RAM between display reads (absolute priority, 2-cycle latency)
// and a FIFO-buffered host writer that drains only in cycles without a display request.
module fb_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 24,
  parameter int WFIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             disp_req,
  input  logic [ADDR_W-1:0]                disp_addr,
  output logic [DATA_W-1:0]                disp_rdata,
  output logic                             disp_rvalid,
  input  logic                             host_wr_valid,
  output logic                             host_wr_ready,
  input  logic [ADDR_W-1:0]                host_addr,
  input  logic [DATA_W-1:0]                host_data,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic [$clog2(WFIFO_DEPTH):0]     fifo_level,
  input  logic                             stat_clr,
  output logic [15:0]                      wr_stall_cnt
);

  localparam int PW = $clog2(WFIFO_DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              disp_gnt;
  logic              host_gnt;
  logic              rdy_en;
  logic              stall;
  logic              rd_pend;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign empty = (wptr == rptr);
  assign full  = (wptr[IW-1:0] == rptr[IW-1:0]) && (wptr[PW-1] != rptr[PW-1]);

  // rdy_en keeps ready low through reset and raises it on the first edge after release.
  assign host_wr_ready = rdy_en & ~full;
  assign push          = host_wr_valid & host_wr_ready;
  assign stall         = host_wr_valid & ~host_wr_ready;
  assign fifo_level    = wptr - rptr;

  // Grants are qualified by reset_n so the RAM port reads all-zero while reset is held.
  assign disp_gnt  = reset_n & disp_req;
  assign host_gnt  = reset_n & ~disp_req & ~empty;
  assign mem_en    = disp_gnt | host_gnt;
  assign mem_we    = host_gnt;
  assign mem_addr  = disp_gnt ? disp_addr
                   : host_gnt ? fifo_addr[rptr[IW-1:0]]
                   : addr_q;
  assign mem_wdata = host_gnt ? fifo_data[rptr[IW-1:0]] : wdata_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr[IW-1:0]] <= host_addr;
      fifo_data[wptr[IW-1:0]] <= host_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      rdy_en       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_pend      <= 1'b0;
      disp_rvalid  <= 1'b0;
      disp_rdata   <= '0;
      wr_stall_cnt <= '0;
    end else begin
      rdy_en  <= 1'b1;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (push) wptr <= wptr + 1'b1;
      if (host_gnt) rptr <= rptr + 1'b1;
      // RAM data for a read issued last cycle is on mem_rdata now.
      rd_pend     <= disp_req;
      disp_rvalid <= rd_pend;
      if (rd_pend) disp_rdata <= mem_rdata;
      if (stat_clr) wr_stall_cnt <= '0;
      else if (stall && wr_stall_cnt != 16'hFFFF) wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle synchronous RAM.
`timescale 1ns/1ps
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_req;
  logic [19:0] disp_addr;
  logic [23:0] disp_rdata;
  logic        disp_rvalid;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [19:0] host_addr;
  logic [23:0] host_data;
  logic        mem_en;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [3:0]  fifo_level;
  logic        stat_clr;
  logic [15:0] wr_stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [23:0] ram [0:4095];

  fb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_addr(host_addr), .host_data(host_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .stat_clr(stat_clr), .wr_stall_cnt(wr_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[11:0]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge clk);
    disp_req  = 1'b1;
    disp_addr = 20'd5;
    for (int i = 0; i < 5; i++) begin
      host_wr_valid = 1'b1;
      host_addr     = 20'(300 + i);
      host_data     = 24'(i + 1);
      @(negedge clk);
    end
    host_wr_valid = 1'b0;
    checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL pre_reset_level: got %0d expected 5", fifo_level); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %0h expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0h expected 0", mem_we); end
    checks++; if (mem_addr !== 20'd0) begin errors++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 24'd0) begin errors++; $display("FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
    checks++; if (host_wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h expected 0", host_wr_ready); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0h expected 0", disp_rvalid); end
    checks++; if (disp_rdata !== 24'd0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", disp_rdata); end
    checks++; if (wr_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", wr_stall_cnt); end
    disp_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (host_wr_ready !== 1'b0) begin errors++; $display("FAIL release_ready_pre_edge: got %0h expected 0", host_wr_ready); end
    @(negedge clk);
    checks++; if (host_wr_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0h expected 1", host_wr_ready); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL release_level: got %0d expected 0", fifo_level); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL release_no_stale_write: got %0h expected 0", mem_en); end
  endtask

  task automatic test_disp_latency();
    int rv_cnt = 0;
    for (int k = 0; k < 1028; k++) begin
      if (disp_rvalid === 1'b1) rv_cnt++;
      if (k >= 2 && k < 1026) begin
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 24'(k - 2)) begin
          errors++;
          $display("FAIL disp_latency[%0d]: got valid=%0h data=%0h expected valid=1 data=%0h", k, disp_rvalid, disp_rdata, k - 2);
        end
      end else if (k < 2) begin
        checks++;
        if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL disp_latency_early[%0d]: got valid=%0h expected 0", k, disp_rvalid); end
      end
      disp_req  = (k < 1024);
      disp_addr = 20'(k);
      @(negedge clk);
    end
    disp_req = 1'b0;
    checks++; if (rv_cnt != 1024) begin errors++; $display("FAIL disp_rvalid_count: got %0d expected 1024", rv_cnt); end
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL disp_rvalid_tail: got %0h expected 0", disp_rvalid); end
  endtask

  task automatic test_active_write();
    disp_req  = 1'b1;
    disp_addr = 20'd0;
    for (int i = 0; i < 3; i++) begin
      host_wr_valid = 1'b1;
      host_addr     = 20'(200 + i);
      host_data     = 24'h110000 + 24'(i);
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL active_no_write[%0d]: got %0h expected 0", i, mem_we); end
      @(negedge clk);
    end
    host_wr_valid = 1'b0;
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL active_level: got %0d expected 3", fifo_level); end
    disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 20'(200 + i) || mem_wdata !== 24'h110000 + 24'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: got we=%0h addr=%0d data=%0h expected we=1 addr=%0d data=%0h",
                 i, mem_we, mem_addr, mem_wdata, 200 + i, 24'h110000 + 24'(i));
      end
      @(negedge clk);
    end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", fifo_level); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL drain_idle: got %0h expected 0", mem_en); end
    checks++; if (mem_addr !== 20'd202) begin errors++; $display("FAIL idle_addr_hold: got %0d expected 202", mem_addr); end
  endtask

  task automatic test_full_stall();
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    disp_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      host_wr_valid = 1'b1;
      host_addr     = 20'(400 + i);
      host_data     = 24'(i);
      @(negedge clk);
    end
    host_wr_valid = 1'b0;
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
    checks++; if (host_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h expected 0", host_wr_ready); end
    checks++; if (wr_stall_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", wr_stall_cnt); end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checks++; if (wr_stall_cnt !== 16'd0) begin errors++; $display("FAIL stat_clr: got %0d expected 0", wr_stall_cnt); end
    disp_req = 1'b0;
    #1;
    checks++; if (host_wr_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_fallthrough: got %0h expected 0", host_wr_ready); end
    repeat (8) @(negedge clk);
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL full_drain_level: got %0d expected 0", fifo_level); end
    checks++; if (ram[407] !== 24'd7) begin errors++; $display("FAIL full_last_write: got %0h expected 7", ram[407]); end
  endtask

  task automatic test_write_readback();
    disp_req      = 1'b0;
    host_wr_valid = 1'b1;
    host_addr     = 20'd100;
    host_data     = 24'hABCDEF;
    @(negedge clk);
    host_wr_valid = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 20'd100) begin errors++; $display("FAIL readback_write: got we=%0h addr=%0d expected we=1 addr=100", mem_we, mem_addr); end
    @(negedge clk);
    disp_req  = 1'b1;
    disp_addr = 20'd100;
    @(negedge clk);
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 24'hABCDEF) begin
      errors++;
      $display("FAIL readback_data: got valid=%0h data=%0h expected valid=1 data=abcdef", disp_rvalid, disp_rdata);
    end
    @(negedge clk);
    checks++; if (disp_rvalid !== 1'b0 || disp_rdata !== 24'hABCDEF) begin errors++; $display("FAIL readback_hold: got valid=%0h data=%0h expected valid=0 data=abcdef", disp_rvalid, disp_rdata); end
  endtask

  task automatic test_saturation_pushpop();
    disp_req      = 1'b1;
    disp_addr     = 20'd0;
    host_wr_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      host_addr = 20'(500 + (i % 16));
      host_data = 24'(i);
      @(negedge clk);
    end
    checks++; if (wr_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %0h expected ffff", wr_stall_cnt); end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checks++; if (wr_stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0h expected 0", wr_stall_cnt); end
    host_wr_valid = 1'b0;
    disp_req      = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL pushpop_pre_level: got %0d expected 4", fifo_level); end
    host_wr_valid = 1'b1;
    host_addr     = 20'd600;
    host_data     = 24'h5A5A5A;
    @(negedge clk);
    host_wr_valid = 1'b0;
    disp_req      = 1'b1;
    checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL pushpop_level: got %0d expected 4", fifo_level); end
    disp_req = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (ram[600] !== 24'h5A5A5A) begin errors++; $display("FAIL pushpop_write: got %0h expected 5a5a5a", ram[600]); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 24'(i);
    reset_n       = 1'b0;
    disp_req      = 1'b0;
    disp_addr     = '0;
    host_wr_valid = 1'b0;
    host_addr     = '0;
    host_data     = '0;
    stat_clr      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_disp_latency();
    test_active_write();
    test_full_stall();
    test_write_readback();
    test_saturation_pushpop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Frame-buffer port arbiter between the VGA scan-out path and a host pixel writer. It shares one synchronous single-port pixel RAM between the two. Display reads have absolute priority and are never stalled. Host writes are buffered in a small FIFO and drained into cycles where the display makes no request, which in practice means horizontal and vertical blanking. The block sits between the sync generator / pixel-address logic and the frame-buffer RAM, and it keeps the established 2-cycle address-to-RGB scan-out latency.

## Interface
- `ADDR_W`, default 20: pixel address width (1024×768 = 786432 words).
- `DATA_W`, default 24: pixel width, {R[7:0], G[7:0], B[7:0]}.
- `WFIFO_DEPTH`, default 8: host write FIFO depth; must be a power of 2, ≥ 2.
- `clk` in 1: pixel clock, 65 MHz.
- `reset_n` in 1: reset, asynchronous, active-low.
- `disp_req` in 1: display needs the pixel at `disp_addr` this cycle; driven from `active_video`.
- `disp_addr` in ADDR_W: display read address.
- `disp_rdata` out DATA_W: pixel returned to the display.
- `disp_rvalid` out 1: `disp_rdata` is valid.
- `host_wr_valid` in 1: host write request.
- `host_wr_ready` out 1: FIFO can accept the request.
- `host_addr` in ADDR_W: host write address.
- `host_data` in DATA_W: host write data.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, valid 1 cycle after a read with `mem_en=1, mem_we=0`.
- `fifo_level` out $clog2(WFIFO_DEPTH)+1: number of entries in the FIFO.
- `stat_clr` in 1: synchronous clear of `wr_stall_cnt`.
- `wr_stall_cnt` out 16: saturating count of cycles with `host_wr_valid && !host_wr_ready`.

## Operation
**Grant, decided per cycle and combinational from registered state plus `disp_req`:**
- **DISP grant:** when `disp_req=1`, the block drives `mem_en=1`, `mem_we=0`, `mem_addr=disp_addr`.
- **HOST grant:** when `disp_req=0` and the FIFO is not empty, the block drives `mem_en=1`, `mem_we=1`, and `mem_addr`/`mem_wdata` from the FIFO head. The head is popped at the clock edge.
- **IDLE:** otherwise, `mem_en=0`, `mem_we=0`, and address/data hold their last value.

**Write FIFO:**
- Circular buffer with read and write pointers of width $clog2(WFIFO_DEPTH)+1; the MSB distinguishes full from empty.
- `host_wr_ready = !full`, and it is 0 while in reset.
- A push happens when `host_wr_valid && host_wr_ready`.
- A push and a pop in the same cycle leave `fifo_level` unchanged.
- If the FIFO is full and the head is popped in the same cycle, ready is still 0 in that cycle. There is no fall-through path.

**Write ordering:**
- Writes reach the RAM in acceptance order.
- A write is never issued in a cycle that has a display read, so there is no read/write collision.
- A display read issued after a write's RAM cycle returns the new data.

**Display path:**
- `mem_rdata` is registered into `disp_rdata`.
- `disp_rvalid` is `disp_req` delayed by 2 flops.
- `disp_rdata` holds its value when `disp_rvalid=0`.

**Statistics:**
- `wr_stall_cnt` increments on each stall cycle and saturates at 16'hFFFF.
- `stat_clr` takes priority over an increment in the same cycle.

**Reset (asynchronous assert):**
- All outputs go to 0.
- The FIFO is emptied and its contents are discarded.
- The valid pipeline is cleared.
- Reset mid-write drops all pending host writes. A RAM write in flight at the assertion edge is not guaranteed.

## Timing
- Display latency is 2 cycles. With `disp_req`/`disp_addr` at cycle N, the RAM returns data at N+1 and `disp_rdata`/`disp_rvalid=1` appear at N+2.
- Host acceptance to RAM write:
  - Minimum 1 cycle: accepted at N, written at N+1 if `disp_req=0` at N+1.
  - Unbounded while `disp_req=1`; the display is never throttled.
- After `reset_n` deasserts, `host_wr_ready` rises on the first clock edge.
- Throughput is one host write per non-display cycle. At 1024×768 there are 320 blanking cycles per line, so a full FIFO drains within one horizontal blank.

## Test plan
- **Reset:** assert `reset_n=0` mid-frame with 5 FIFO entries → all outputs are 0 immediately; after release, `fifo_level=0` and `host_wr_ready=1` on the first edge.
- **Display latency:** `disp_req=1` for 1024 cycles with addresses 0..1023 over a RAM preloaded with addr-as-data → `disp_rdata` equals the address 2 cycles later, and `disp_rvalid` is high for exactly 1024 cycles.
- **Write during active video:** push 3 writes while `disp_req=1` → `mem_we` stays 0 and `fifo_level=3`; `disp_req` falls → 3 writes on 3 consecutive cycles, in order, then `fifo_level=0`.
- **Full FIFO and stalls:** hold `host_wr_valid=1` for 12 cycles with `disp_req=1` and depth 8 → 8 accepted, `host_wr_ready=0`, `wr_stall_cnt=4`; assert `stat_clr` → count reads 0.
- **Write then read back:** write `0xABCDEF` to address 100 during blanking, then `disp_req` at address 100 → `disp_rdata=0xABCDEF` at +2 cycles.
- **Saturation and simultaneous push/pop:** force 70000 stall cycles → `wr_stall_cnt=0xFFFF`; push and pop in the same cycle at level 4 → level stays 4.
